// File: rtl/w5300_tx_scheduler.sv
// Round-robin TX scheduler in front of w5300_entry: grants one of two UDP requesters,
// issues a one-cycle tx_req and follows the busy_n handshake with per-phase timeouts.
module w5300_tx_scheduler #(
   parameter int CLK_FREQ   = 100,
   parameter int TIMEOUT_US = 10000,
   parameter int LEN_WIDTH  = 12
) (
   input  logic                 wclk0,
   input  logic                 rst_n,
   input  logic                 i_init_done,
   input  logic                 i_busy_n,
   input  logic [1:0]           i_req,
   input  logic [LEN_WIDTH-1:0] i_len0,
   input  logic [LEN_WIDTH-1:0] i_len1,
   output logic                 o_tx_req,
   output logic [LEN_WIDTH-1:0] o_tx_len,
   output logic                 o_tx_sel,
   output logic [1:0]           o_ack,
   output logic                 o_err,
   output logic                 o_sched_busy
);

   localparam int TMO = CLK_FREQ * TIMEOUT_US;
   localparam int TW  = $clog2(TMO) + 1;
   localparam logic [TW-1:0] TMO_M1 = TW'(TMO - 1);

   typedef enum logic [2:0] {
      S_WAIT_INIT,
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACC,
      S_WAIT_DONE
   } state_t;

   state_t                 r_state, w_nxt_state;
   logic                   r_rr_last, w_rr_last;
   logic [TW-1:0]          r_timer;
   logic                   r_tx_req, r_tx_sel, r_err, r_sched_busy;
   logic [LEN_WIDTH-1:0]   r_tx_len;
   logic [1:0]             r_ack;

   logic                   w_tx_req, w_tx_sel, w_err, w_timer_clr, w_gsel, w_tmo;
   logic [LEN_WIDTH-1:0]   w_tx_len, w_glen;
   logic [1:0]             w_ack;

   assign w_tmo = (r_timer == TMO_M1);

   always_ff @(posedge wclk0 or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_WAIT_INIT;
         r_rr_last    <= 1'b1;
         r_tx_req     <= 1'b0;
         r_tx_sel     <= 1'b0;
         r_tx_len     <= '0;
         r_ack        <= 2'b00;
         r_err        <= 1'b0;
         r_sched_busy <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_rr_last    <= w_rr_last;
         r_tx_req     <= w_tx_req;
         r_tx_sel     <= w_tx_sel;
         r_tx_len     <= w_tx_len;
         r_ack        <= w_ack;
         r_err        <= w_err;
         r_sched_busy <= (w_nxt_state != S_IDLE);
      end
   end

   // Saturating phase timer; it only advances while waiting on busy_n.
   always_ff @(posedge wclk0 or negedge rst_n) begin
      if (!rst_n)
         r_timer <= '0;
      else if (w_timer_clr)
         r_timer <= '0;
      else if ((r_state == S_WAIT_ACC || r_state == S_WAIT_DONE) && (r_timer != {TW{1'b1}}))
         r_timer <= r_timer + 1'b1;
   end

   always_comb begin
      w_nxt_state = r_state;
      w_rr_last   = r_rr_last;
      w_tx_req    = 1'b0;
      w_tx_sel    = r_tx_sel;
      w_tx_len    = r_tx_len;
      w_ack       = 2'b00;
      w_err       = 1'b0;
      w_timer_clr = 1'b0;
      w_gsel      = (i_req == 2'b11) ? ~r_rr_last : i_req[1];
      w_glen      = w_gsel ? i_len1 : i_len0;
      if (!i_init_done) begin
         // Losing init abandons any transfer silently.
         w_nxt_state = S_WAIT_INIT;
      end else begin
         case (r_state)
            S_WAIT_INIT: w_nxt_state = S_IDLE;
            S_IDLE: begin
               if (|i_req) begin
                  w_tx_sel = w_gsel;
                  w_tx_len = w_glen;
                  if (w_glen == '0) begin
                     w_err         = 1'b1;
                     w_ack[w_gsel] = 1'b1;
                     w_rr_last     = w_gsel;
                  end else begin
                     w_nxt_state = S_ISSUE;
                     w_tx_req    = 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               w_timer_clr = 1'b1;
               w_nxt_state = S_WAIT_ACC;
            end
            S_WAIT_ACC: begin
               if (!i_busy_n) begin
                  w_timer_clr = 1'b1;
                  w_nxt_state = S_WAIT_DONE;
               end else if (w_tmo) begin
                  w_err       = 1'b1;
                  w_nxt_state = S_IDLE;
               end
            end
            S_WAIT_DONE: begin
               if (i_busy_n) begin
                  w_ack[r_tx_sel] = 1'b1;
                  w_rr_last       = r_tx_sel;
                  w_nxt_state     = S_IDLE;
               end else if (w_tmo) begin
                  w_err       = 1'b1;
                  w_nxt_state = S_IDLE;
               end
            end
            default: w_nxt_state = S_WAIT_INIT;
         endcase
      end
   end

   assign o_tx_req     = r_tx_req;
   assign o_tx_len     = r_tx_len;
   assign o_tx_sel     = r_tx_sel;
   assign o_ack        = r_ack;
   assign o_err        = r_err;
   assign o_sched_busy = r_sched_busy;

endmodule

// File: tb/tb_w5300_tx_scheduler.sv
// Directed bench for w5300_tx_scheduler: cycle-level vector table plus handshake sequences.
module tb_w5300_tx_scheduler;

   logic        wclk0 = 1'b0;
   logic        rst_n;
   logic        init_done;
   logic        busy_n;
   logic [1:0]  req;
   logic [11:0] len0, len1;
   logic        tx_req, tx_sel, err, sched_busy;
   logic [11:0] tx_len;
   logic [1:0]  ack;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 wclk0 = ~wclk0;

   w5300_tx_scheduler #(.CLK_FREQ(100), .TIMEOUT_US(1), .LEN_WIDTH(12)) dut (
      .wclk0       (wclk0),
      .rst_n       (rst_n),
      .i_init_done (init_done),
      .i_busy_n    (busy_n),
      .i_req       (req),
      .i_len0      (len0),
      .i_len1      (len1),
      .o_tx_req    (tx_req),
      .o_tx_len    (tx_len),
      .o_tx_sel    (tx_sel),
      .o_ack       (ack),
      .o_err       (err),
      .o_sched_busy(sched_busy)
   );

   typedef struct {
      logic        init, busy;
      logic [1:0]  rq;
      logic [11:0] l0, l1;
      logic        xreq, xsel;
      logic [11:0] xlen;
      logic [1:0]  xack;
      logic        xerr, xsb;
   } vec_t;

   vec_t tv[17];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; init_done = 1'b0; busy_n = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
      repeat (2) @(negedge wclk0);
      rst_n = 1'b1;
   endtask

   // Serve one transfer: busy_n falls 2 cycles after tx_req and rises 20 cycles later.
   task automatic serve(input string nm, input logic xsel, input logic [11:0] xlen, input logic [1:0] xack);
      logic found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         if (tx_req) found = 1'b1;
         else @(negedge wclk0);
      end
      check({nm, "_txreq_seen"}, 32'(found), 32'd1);
      check({nm, "_sel_len"}, {19'd0, tx_sel, tx_len}, {19'd0, xsel, xlen});
      repeat (2) @(negedge wclk0);
      busy_n = 1'b0;
      repeat (20) @(negedge wclk0);
      busy_n = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
         @(negedge wclk0);
         if (ack != 2'b00 || err) found = 1'b1;
      end
      check({nm, "_ack_err"}, {29'd0, ack, err}, {29'd0, xack, 1'b0});
      @(negedge wclk0);
      check({nm, "_ack_width"}, 32'(ack), 32'd0);
   endtask

   initial begin
      int cnt;
      logic seen, bad;
      //         init busy rq     l0     l1    xreq xsel xlen   xack   xerr xsb
      tv[0]  = '{1'b0, 1'b1, 2'b00, 12'd5, 12'd7, 1'b0, 1'b0, 12'd0, 2'b00, 1'b0, 1'b1};
      tv[1]  = '{1'b1, 1'b1, 2'b00, 12'd5, 12'd7, 1'b0, 1'b0, 12'd0, 2'b00, 1'b0, 1'b0};
      tv[2]  = '{1'b1, 1'b1, 2'b01, 12'd5, 12'd7, 1'b1, 1'b0, 12'd5, 2'b00, 1'b0, 1'b1};
      tv[3]  = '{1'b1, 1'b1, 2'b01, 12'd5, 12'd7, 1'b0, 1'b0, 12'd5, 2'b00, 1'b0, 1'b1};
      tv[4]  = '{1'b1, 1'b0, 2'b01, 12'd5, 12'd7, 1'b0, 1'b0, 12'd5, 2'b00, 1'b0, 1'b1};
      tv[5]  = '{1'b1, 1'b0, 2'b01, 12'd5, 12'd7, 1'b0, 1'b0, 12'd5, 2'b00, 1'b0, 1'b1};
      tv[6]  = '{1'b1, 1'b1, 2'b01, 12'd5, 12'd7, 1'b0, 1'b0, 12'd5, 2'b01, 1'b0, 1'b0};
      tv[7]  = '{1'b1, 1'b1, 2'b00, 12'd5, 12'd7, 1'b0, 1'b0, 12'd5, 2'b00, 1'b0, 1'b0};
      tv[8]  = '{1'b1, 1'b1, 2'b11, 12'd5, 12'd7, 1'b1, 1'b1, 12'd7, 2'b00, 1'b0, 1'b1};
      tv[9]  = '{1'b1, 1'b1, 2'b00, 12'd5, 12'd9, 1'b0, 1'b1, 12'd7, 2'b00, 1'b0, 1'b1};
      tv[10] = '{1'b1, 1'b0, 2'b00, 12'd5, 12'd9, 1'b0, 1'b1, 12'd7, 2'b00, 1'b0, 1'b1};
      tv[11] = '{1'b1, 1'b1, 2'b00, 12'd5, 12'd9, 1'b0, 1'b1, 12'd7, 2'b10, 1'b0, 1'b0};
      tv[12] = '{1'b1, 1'b1, 2'b10, 12'd5, 12'd0, 1'b0, 1'b1, 12'd0, 2'b10, 1'b1, 1'b0};
      tv[13] = '{1'b1, 1'b1, 2'b00, 12'd5, 12'd0, 1'b0, 1'b1, 12'd0, 2'b00, 1'b0, 1'b0};
      tv[14] = '{1'b1, 1'b1, 2'b11, 12'd3, 12'd4, 1'b1, 1'b0, 12'd3, 2'b00, 1'b0, 1'b1};
      tv[15] = '{1'b0, 1'b1, 2'b11, 12'd3, 12'd4, 1'b0, 1'b0, 12'd3, 2'b00, 1'b0, 1'b1};
      tv[16] = '{1'b1, 1'b1, 2'b00, 12'd3, 12'd4, 1'b0, 1'b0, 12'd3, 2'b00, 1'b0, 1'b0};

      // Reset state
      rst_n = 1'b0; init_done = 1'b0; busy_n = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
      #3;
      check("reset_outputs", {14'd0, tx_req, tx_sel, tx_len, ack, err, sched_busy}, 32'd0);

      // Cycle-level vector table
      do_reset();
      for (int i = 0; i < 17; i++) begin
         init_done = tv[i].init; busy_n = tv[i].busy; req = tv[i].rq;
         len0 = tv[i].l0; len1 = tv[i].l1;
         @(posedge wclk0); #1;
         check($sformatf("vec%0d", i),
               {14'd0, tx_req, tx_sel, tx_len, ack, err, sched_busy},
               {14'd0, tv[i].xreq, tv[i].xsel, tv[i].xlen, tv[i].xack, tv[i].xerr, tv[i].xsb});
         @(negedge wclk0);
      end

      // T1: no grant before init_done
      do_reset();
      req = 2'b01; len0 = 12'd10;
      bad = 1'b0;
      repeat (100) begin
         @(negedge wclk0);
         if (tx_req || !sched_busy) bad = 1'b1;
      end
      check("t1_hold_in_wait_init", 32'(bad), 32'd0);
      init_done = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 3 && !seen; k++) begin
         @(negedge wclk0);
         if (tx_req) seen = 1'b1;
      end
      check("t1_txreq_within_3", 32'(seen), 32'd1);
      check("t1_sel", 32'(tx_sel), 32'd0);

      // T2: round-robin alternation with a modelled handshake
      do_reset();
      init_done = 1'b1; req = 2'b11; len0 = 12'd64; len1 = 12'd128;
      serve("t2_g0", 1'b0, 12'd64,  2'b01);
      serve("t2_g1", 1'b1, 12'd128, 2'b10);
      serve("t2_g2", 1'b0, 12'd64,  2'b01);

      // T3: zero-length reject
      do_reset();
      init_done = 1'b1; req = 2'b01; len0 = 12'd0;
      seen = 1'b0; bad = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
         @(negedge wclk0);
         if (tx_req) bad = 1'b1;
         if (err) seen = 1'b1;
      end
      check("t3_err_and_ack", {29'd0, ack, err}, {29'd0, 2'b01, 1'b1});
      req = 2'b00;
      @(negedge wclk0);
      check("t3_pulse_width", {29'd0, ack, err}, 32'd0);
      check("t3_no_txreq", 32'(bad | tx_req), 32'd0);

      // T4: accept-phase timeout (TMO = 100 cycles)
      do_reset();
      init_done = 1'b1; req = 2'b01; len0 = 12'd20;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge wclk0);
         if (tx_req) seen = 1'b1;
      end
      check("t4_txreq_seen", 32'(seen), 32'd1);
      cnt = 0; seen = 1'b0; bad = 1'b0;
      while (!seen && cnt < 150) begin
         @(negedge wclk0);
         cnt++;
         if (ack != 2'b00) bad = 1'b1;
         if (err) seen = 1'b1;
      end
      check("t4_err_delay", 32'(cnt), 32'd101);
      check("t4_no_ack", 32'(bad), 32'd0);
      serve("t4_next", 1'b0, 12'd20, 2'b01);

      // T5: init_done drop during WAIT_DONE
      do_reset();
      init_done = 1'b1; req = 2'b01; len0 = 12'd30;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge wclk0);
         if (tx_req) seen = 1'b1;
      end
      check("t5_txreq_seen", 32'(seen), 32'd1);
      repeat (2) @(negedge wclk0);
      busy_n = 1'b0;
      repeat (3) @(negedge wclk0);
      init_done = 1'b0;
      bad = 1'b0;
      repeat (5) begin
         @(negedge wclk0);
         if (ack != 2'b00 || err || tx_req || !sched_busy) bad = 1'b1;
      end
      check("t5_abandon_silent", 32'(bad), 32'd0);
      busy_n = 1'b1; init_done = 1'b1;
      serve("t5_regrant", 1'b0, 12'd30, 2'b01);

      // T6: async reset during WAIT_ACC
      do_reset();
      init_done = 1'b1; req = 2'b01; len0 = 12'd40; len1 = 12'd50;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge wclk0);
         if (tx_req) seen = 1'b1;
      end
      check("t6_txreq_seen", 32'(seen), 32'd1);
      @(negedge wclk0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_clear", {14'd0, tx_req, tx_sel, tx_len, ack, err, sched_busy}, 32'd0);
      req = 2'b11;
      @(negedge wclk0);
      rst_n = 1'b1;
      serve("t6_first_grant", 1'b0, 12'd40, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
